// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: groups the pipeline, late-result, issue, register-file
// write and decode-bypass signals of the writeback arbiter.
// The slave modport is the arbiter side; the master modport is the
// surrounding core (or a testbench) that drives results and consumes writes.
interface wb_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
);
  logic                  pipe_valid;
  logic [4:0]            pipe_rd;
  logic [DATA_WIDTH-1:0] pipe_data;
  logic                  late_valid;
  logic                  late_ready;
  logic [4:0]            late_rd;
  logic [DATA_WIDTH-1:0] late_data;
  logic                  issue_valid;
  logic [4:0]            issue_rd;
  logic [31:0]           pending;
  logic [CNT_W-1:0]      fifo_count;
  logic                  rf_wen;
  logic [4:0]            rf_rd;
  logic [DATA_WIDTH-1:0] rf_wrdata;
  logic [4:0]            rs1;
  logic [4:0]            rs2;
  logic                  byp1_hit;
  logic                  byp2_hit;
  logic [DATA_WIDTH-1:0] byp1_data;
  logic [DATA_WIDTH-1:0] byp2_data;

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data,
    input  late_valid, late_rd, late_data,
    input  issue_valid, issue_rd,
    input  rs1, rs2,
    output late_ready, pending, fifo_count,
    output rf_wen, rf_rd, rf_wrdata,
    output byp1_hit, byp2_hit, byp1_data, byp2_data
  );

  modport master (
    output pipe_valid, pipe_rd, pipe_data,
    output late_valid, late_rd, late_data,
    output issue_valid, issue_rd,
    output rs1, rs2,
    input  late_ready, pending, fifo_count,
    input  rf_wen, rf_rd, rf_wrdata,
    input  byp1_hit, byp2_hit, byp1_data, byp2_data
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges single-cycle pipeline results with buffered
// long-latency results into one registered register-file write per cycle,
// and tracks outstanding long-latency destinations in a pending scoreboard.
// Pipeline results have priority; the late-result FIFO drains only on
// cycles without a real pipeline write.
// Optional feature: define WB_BYPASS_EN to enable combinational forwarding
// of the registered write to the decode read ports rs1/rs2.
module wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_arbiter_if.slave   bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // FIFO storage and pointers
  logic [4:0]            fifo_rd_q   [FIFO_DEPTH];
  logic [4:0]            fifo_rd_d   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  // Scoreboard and registered write port
  logic [31:0]           pending_q, pending_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [4:0]            rf_rd_q, rf_rd_d;
  logic [DATA_WIDTH-1:0] rf_wrdata_q, rf_wrdata_d;

  // Per-cycle decisions
  logic                  late_ready_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  pipe_wr_s;
  logic [4:0]            head_rd_s;
  logic [DATA_WIDTH-1:0] head_data_s;

  // Ready depends only on occupancy, so a pop in the same cycle never
  // lets a push into a full FIFO.
  assign late_ready_s = (count_q != CNT_W'(FIFO_DEPTH));

  // Arbitration, FIFO update, scoreboard update and write-port next state
  always_comb begin
    pipe_wr_s   = bus.pipe_valid && (bus.pipe_rd != 5'd0);
    push_s      = bus.late_valid && late_ready_s;
    pop_s       = !pipe_wr_s && (count_q != {CNT_W{1'b0}});
    head_rd_s   = fifo_rd_q[rd_ptr_q];
    head_data_s = fifo_data_q[rd_ptr_q];

    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    pending_d   = pending_q;
    rf_wen_d    = 1'b0;
    rf_rd_d     = 5'd0;
    rf_wrdata_d = {DATA_WIDTH{1'b0}};

    if (push_s) begin
      fifo_rd_d[wr_ptr_q]   = bus.late_rd;
      fifo_data_d[wr_ptr_q] = bus.late_data;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      pending_d[head_rd_s] = 1'b0;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);

    // Issue is applied after the pop clear so a same-register race keeps it set.
    if (bus.issue_valid && (bus.issue_rd != 5'd0)) begin
      pending_d[bus.issue_rd] = 1'b1;
    end else begin
      pending_d[0] = 1'b0;
    end
    pending_d[0] = 1'b0;

    if (pipe_wr_s) begin
      rf_wen_d    = 1'b1;
      rf_rd_d     = bus.pipe_rd;
      rf_wrdata_d = bus.pipe_data;
    end else if (pop_s && (head_rd_s != 5'd0)) begin
      rf_wen_d    = 1'b1;
      rf_rd_d     = head_rd_s;
      rf_wrdata_d = head_data_s;
    end else begin
      rf_wen_d    = 1'b0;
    end
  end

  // State registers; reset empties the FIFO and clears the scoreboard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_rd_q[i]   <= 5'd0;
        fifo_data_q[i] <= {DATA_WIDTH{1'b0}};
      end
      rd_ptr_q    <= {PTR_W{1'b0}};
      wr_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      pending_q   <= 32'd0;
      rf_wen_q    <= 1'b0;
      rf_rd_q     <= 5'd0;
      rf_wrdata_q <= {DATA_WIDTH{1'b0}};
    end else begin
      fifo_rd_q   <= fifo_rd_d;
      fifo_data_q <= fifo_data_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      pending_q   <= pending_d;
      rf_wen_q    <= rf_wen_d;
      rf_rd_q     <= rf_rd_d;
      rf_wrdata_q <= rf_wrdata_d;
    end
  end

  assign bus.late_ready = late_ready_s;
  assign bus.fifo_count = count_q;
  assign bus.pending    = pending_q;
  assign bus.rf_wen     = rf_wen_q;
  assign bus.rf_rd      = rf_rd_q;
  assign bus.rf_wrdata  = rf_wrdata_q;

`ifdef WB_BYPASS_EN
  // Forward the in-flight write while the register file still returns the old value
  always_comb begin
    bus.byp1_hit  = rf_wen_q && (rf_rd_q == bus.rs1) && (bus.rs1 != 5'd0);
    bus.byp2_hit  = rf_wen_q && (rf_rd_q == bus.rs2) && (bus.rs2 != 5'd0);
    bus.byp1_data = rf_wrdata_q;
    bus.byp2_data = rf_wrdata_q;
  end
`else
  logic unused_rs_s;
  assign unused_rs_s   = ^{bus.rs1, bus.rs2};
  assign bus.byp1_hit  = 1'b0;
  assign bus.byp2_hit  = 1'b0;
  assign bus.byp1_data = {DATA_WIDTH{1'b0}};
  assign bus.byp2_data = {DATA_WIDTH{1'b0}};
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed checks of reset, pipe path, priority/drain,
// full-FIFO back-pressure, scoreboard race and decode bypass.
module tb_wb_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

`ifdef WB_BYPASS_EN
  localparam logic BYP_ON = 1'b1;
`else
  localparam logic BYP_ON = 1'b0;
`endif

  wb_arbiter_if #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) bus ();

  wb_arbiter #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then return on the falling edge for driving and sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_wr(input string tag, input logic wen, input logic [4:0] rd, input logic [31:0] data);
    chk({tag, ".wen"}, {63'd0, bus.rf_wen}, {63'd0, wen});
    chk({tag, ".rd"}, {59'd0, bus.rf_rd}, {59'd0, rd});
    chk({tag, ".data"}, {32'd0, bus.rf_wrdata}, {32'd0, data});
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.pipe_valid = 1'b0; bus.pipe_rd = 5'd0; bus.pipe_data = 32'd0;
    bus.late_valid = 1'b0; bus.late_rd = 5'd0; bus.late_data = 32'd0;
    bus.issue_valid = 1'b0; bus.issue_rd = 5'd0;
    bus.rs1 = 5'd0; bus.rs2 = 5'd0;
    step();
    step();

    // Reset state
    chk_wr("reset", 1'b0, 5'd0, 32'd0);
    chk("reset.count", {61'd0, bus.fifo_count}, 64'd0);
    chk("reset.ready", {63'd0, bus.late_ready}, 64'd1);
    chk("reset.pending", {32'd0, bus.pending}, 64'd0);
    chk("reset.byp1", {63'd0, bus.byp1_hit}, 64'd0);
    rst_n = 1'b1;
    step();

    // Pipe path
    bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd5; bus.pipe_data = 32'hDEADBEEF;
    step();
    chk_wr("pipe5", 1'b1, 5'd5, 32'hDEADBEEF);
    bus.pipe_rd = 5'd0; bus.pipe_data = 32'h12345678;
    step();
    chk("pipe_r0.wen", {63'd0, bus.rf_wen}, 64'd0);

    // Bypass
    bus.pipe_rd = 5'd4; bus.pipe_data = 32'hCAFE0004;
    bus.rs1 = 5'd4; bus.rs2 = 5'd0;
    step();
    chk_wr("byp.wr", 1'b1, 5'd4, 32'hCAFE0004);
    chk("byp1.hit", {63'd0, bus.byp1_hit}, {63'd0, BYP_ON});
    chk("byp1.data", {32'd0, bus.byp1_data}, BYP_ON ? 64'hCAFE0004 : 64'd0);
    chk("byp2.hit_r0", {63'd0, bus.byp2_hit}, 64'd0);
    bus.rs2 = 5'd4;
    #1;
    chk("byp2.hit", {63'd0, bus.byp2_hit}, {63'd0, BYP_ON});
    bus.rs1 = 5'd6;
    #1;
    chk("byp1.miss", {63'd0, bus.byp1_hit}, 64'd0);
    bus.rs1 = 5'd0; bus.rs2 = 5'd0;

    // Priority / drain
    bus.pipe_valid = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    step();
    chk("issue7.pending", {32'd0, bus.pending}, 64'h80);
    bus.issue_valid = 1'b0;
    bus.late_valid = 1'b1; bus.late_rd = 5'd7; bus.late_data = 32'h11;
    bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd3; bus.pipe_data = 32'hA0;
    step();
    bus.late_valid = 1'b0;
    chk_wr("prio1", 1'b1, 5'd3, 32'hA0);
    chk("prio1.count", {61'd0, bus.fifo_count}, 64'd1);
    bus.pipe_data = 32'hA1;
    step();
    chk_wr("prio2", 1'b1, 5'd3, 32'hA1);
    chk("prio2.count", {61'd0, bus.fifo_count}, 64'd1);
    bus.pipe_data = 32'hA2;
    step();
    chk_wr("prio3", 1'b1, 5'd3, 32'hA2);
    chk("prio3.count", {61'd0, bus.fifo_count}, 64'd1);
    chk("prio3.pending", {32'd0, bus.pending}, 64'h80);
    bus.pipe_valid = 1'b0;
    step();
    chk_wr("drain7", 1'b1, 5'd7, 32'h11);
    chk("drain7.count", {61'd0, bus.fifo_count}, 64'd0);
    chk("drain7.pending", {32'd0, bus.pending}, 64'd0);

    // Full FIFO: pipe traffic blocks pops while four entries are pushed
    bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd1; bus.pipe_data = 32'hB0;
    bus.late_valid = 1'b1;
    bus.late_rd = 5'd10; bus.late_data = 32'h100; step();
    bus.late_rd = 5'd11; bus.late_data = 32'h101; step();
    bus.late_rd = 5'd12; bus.late_data = 32'h102; step();
    chk("fill3.ready", {63'd0, bus.late_ready}, 64'd1);
    bus.late_rd = 5'd13; bus.late_data = 32'h103; step();
    chk("full.count", {61'd0, bus.fifo_count}, 64'd4);
    chk("full.ready", {63'd0, bus.late_ready}, 64'd0);
    bus.late_rd = 5'd14; bus.late_data = 32'h5; step();
    chk("full.hold_count", {61'd0, bus.fifo_count}, 64'd4);
    bus.pipe_valid = 1'b0;
    step();
    chk_wr("pop10", 1'b1, 5'd10, 32'h100);
    chk("pop10.count", {61'd0, bus.fifo_count}, 64'd3);
    chk("pop10.ready", {63'd0, bus.late_ready}, 64'd1);
    step();
    bus.late_valid = 1'b0;
    chk_wr("pop11", 1'b1, 5'd11, 32'h101);
    chk("pop11.count", {61'd0, bus.fifo_count}, 64'd3);
    step();
    chk_wr("pop12", 1'b1, 5'd12, 32'h102);
    step();
    chk_wr("pop13", 1'b1, 5'd13, 32'h103);
    step();
    chk_wr("pop14", 1'b1, 5'd14, 32'h5);
    chk("pop14.count", {61'd0, bus.fifo_count}, 64'd0);

    // Scoreboard race and rd=0 handling
    bus.late_valid = 1'b1; bus.late_rd = 5'd9; bus.late_data = 32'h99;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    step();
    bus.late_valid = 1'b0;
    chk("race.pre_pending", {32'd0, bus.pending}, 64'h200);
    step();
    chk_wr("race.pop9", 1'b1, 5'd9, 32'h99);
    chk("race.pending", {32'd0, bus.pending}, 64'h200);
    bus.issue_rd = 5'd0;
    step();
    chk("issue0.pending", {32'd0, bus.pending}, 64'h200);
    bus.issue_valid = 1'b0;
    bus.late_valid = 1'b1; bus.late_rd = 5'd0; bus.late_data = 32'h77;
    step();
    bus.late_valid = 1'b0;
    step();
    chk("pop_r0.wen", {63'd0, bus.rf_wen}, 64'd0);
    chk("pop_r0.count", {61'd0, bus.fifo_count}, 64'd0);
    chk("pop_r0.pending", {32'd0, bus.pending}, 64'h200);

    // Asynchronous reset in the middle of traffic
    bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd2; bus.pipe_data = 32'hEE;
    bus.late_valid = 1'b1; bus.late_rd = 5'd8; bus.late_data = 32'h88;
    step();
    chk("mid.count", {61'd0, bus.fifo_count}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_wr("async_rst", 1'b0, 5'd0, 32'd0);
    chk("async_rst.count", {61'd0, bus.fifo_count}, 64'd0);
    chk("async_rst.ready", {63'd0, bus.late_ready}, 64'd1);
    chk("async_rst.pending", {32'd0, bus.pending}, 64'd0);
    bus.pipe_valid = 1'b0; bus.late_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst.count", {61'd0, bus.fifo_count}, 64'd0);
    chk("post_rst.wen", {63'd0, bus.rf_wen}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter sitting directly upstream of the integer register file write port. It merges single-cycle pipeline results with out-of-order long-latency results (loads, mul/div) buffered in a small FIFO. It drives one registered write per cycle to the register file and keeps a per-register pending scoreboard for hazard detection in decode.

## Interface
Parameters:
- DATA_WIDTH, 32, width of write data
- FIFO_DEPTH, 4, late-result buffer entries; power of two, >= 2
- CNT_W, $clog2(FIFO_DEPTH)+1, width of fifo_count

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- pipe_valid  in  1  pipeline result present this cycle
- pipe_rd  in  5  pipeline destination register
- pipe_data  in  DATA_WIDTH  pipeline result
- late_valid  in  1  long-latency result offered
- late_ready  out  1  FIFO can accept; equals (fifo_count != FIFO_DEPTH)
- late_rd  in  5  long-latency destination register
- late_data  in  DATA_WIDTH  long-latency result
- issue_valid  in  1  long-latency op issued this cycle
- issue_rd  in  5  its destination register
- pending  out  32  scoreboard, bit i = register i awaiting a late result
- fifo_count  out  CNT_W  FIFO occupancy
- rf_wen  out  1  register file write enable (registered)
- rf_rd  out  5  register file write index (registered)
- rf_wrdata  out  DATA_WIDTH  register file write data (registered)
- rs1, rs2  in  5  decode read indices (bypass compare)
- byp1_hit, byp2_hit  out  1  forward valid for rs1/rs2
- byp1_data, byp2_data  out  DATA_WIDTH  forwarded data

## Operation
- Accept: late entry pushed when late_valid && late_ready. A push is refused when full, even if a pop occurs that cycle.
- Selection, each cycle, highest first:
  - pipe_valid && pipe_rd != 0: pipeline write; FIFO holds.
  - FIFO non-empty: pop head; write head if head rd != 0, else pop with no write.
  - Otherwise: no write.
- pipe_valid with pipe_rd == 0 is dropped and does not block a FIFO pop.
- FIFO order is strict FIFO; pointers wrap modulo FIFO_DEPTH.
- Scoreboard:
  - issue_valid with issue_rd != 0 sets pending[issue_rd].
  - A FIFO pop clears pending[head rd].
  - If set and clear hit the same register in the same cycle, set wins.
  - pending[0] is constant 0.
- A pipeline write to a register whose pending bit is set is not checked; upstream must stall.

## Timing
- Reset (async assert, sync release of effect on next edge): rf_wen=0, rf_rd=0, rf_wrdata=0, pending=0, FIFO empty, fifo_count=0, late_ready=1, byp*_hit=0, byp*_data=0.
- Pipeline result at edge N appears on rf_* after edge N. The register file commits it at edge N+1.
- A late result pushed at edge N is earliest on rf_* after edge N+1 (empty FIFO, no pipe traffic).
- fifo_count and pending update on the same edge as the push/pop/issue.
- late_ready is combinational from fifo_count only; no combinational path from late_valid.
- Continuous pipe traffic starves the FIFO indefinitely; this is by design.
- Reset mid-operation discards FIFO contents and clears the scoreboard.

## Configuration
- WB_BYPASS_EN defined:
  - byp1_hit = rf_wen && rf_rd == rs1 && rs1 != 0; byp1_data = rf_wrdata. rs2 likewise.
  - These are combinational and cover the cycle in which the register file still returns the old value.
- WB_BYPASS_EN undefined: byp*_hit and byp*_data tied to 0; rs1/rs2 unused.

## Test plan
- Reset: assert rst_n=0 mid-traffic -> all outputs 0, late_ready=1, fifo_count=0 immediately (async).
- Pipe path: pipe_valid=1, pipe_rd=5, pipe_data=0xDEADBEEF -> next cycle rf_wen=1, rf_rd=5, rf_wrdata=0xDEADBEEF. With pipe_rd=0 -> rf_wen=0.
- Priority/drain: push late rd=7 data=0x11, hold pipe_valid=1 (rd=3) for 3 cycles -> three rd=3 writes, fifo_count stays 1. Drop pipe_valid -> rd=7 data=0x11 written, pending[7] clears, count 0.
- Full: push 4 entries with no pops -> late_ready=0 at count 4. 5th late_valid held is not accepted until a pop, then accepted the following cycle. Written order matches push order.
- Scoreboard race: issue_rd=9 in the same cycle the FIFO pops rd=9 -> pending[9]=1 afterwards. issue_rd=0 -> pending stays 0.
- Bypass (WB_BYPASS_EN): rf_wen=1, rf_rd=4, rs1=4, rs2=0 -> byp1_hit=1 with byp1_data=rf_wrdata, byp2_hit=0. Without the macro -> both 0.
